axi_slave_wr_ctrl: RTL and testbench

Slave-side AXI write-path controller: accepts one write burst at a time on AW/W, drives a word-addressed SRAM write port, and issues the B response carrying the extended ID (`AXI_IDS_BITS`) that the interconnect's B channel routes back to the originating master. One instance sits in front of each memory-mapped slave (ROM/IM/DM/accelerator buffers). It is the producer of `ids_sX_i/resp_sX_i/valid_sX_i` and the consumer of `ready_sX_o` on the interconnect.

---
 rtl/axi_slave_wr_ctrl_pkg.sv | 13 +
 rtl/axi_slave_wr_ctrl.sv | 91 +++++++++
 tb/tb_axi_slave_wr_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_wr_ctrl_pkg.sv
// axi_slave_wr_ctrl_pkg: shared AXI widths, encodings and write-FSM states.
package axi_slave_wr_ctrl_pkg;
   localparam int AXI_IDS_BITS  = 8;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;
   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE_WORD = 3'b010;
   typedef enum logic [1:0] {IDLE, DATA, RESP} wr_state_e;
endpackage

// File: rtl/axi_slave_wr_ctrl.sv
// axi_slave_wr_ctrl: single-burst AXI write slave driving a word-addressed SRAM port.
module axi_slave_wr_ctrl
   import axi_slave_wr_ctrl_pkg::*;
#(
   parameter int ADDR_WORDS = 16384
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AXI_IDS_BITS-1:0]  awid_i,
   input  logic [AXI_ADDR_BITS-1:0] awaddr_i,
   input  logic [AXI_LEN_BITS-1:0]  awlen_i,
   input  logic [AXI_SIZE_BITS-1:0] awsize_i,
   input  logic [1:0]               awburst_i,
   input  logic                     awvalid_i,
   output logic                     awready_o,
   input  logic [31:0]              wdata_i,
   input  logic [3:0]               wstrb_i,
   input  logic                     wlast_i,
   input  logic                     wvalid_i,
   output logic                     wready_o,
   output logic [AXI_IDS_BITS-1:0]  bid_o,
   output logic [1:0]               bresp_o,
   output logic                     bvalid_o,
   input  logic                     bready_i,
   output logic                     mem_cs_o,
   output logic [3:0]               mem_we_o,
   output logic [13:0]              mem_addr_o,
   output logic [31:0]              mem_di_o
);
   localparam logic [31:0] WORDS = 32'(ADDR_WORDS);
   localparam logic [31:0] LIMIT = 32'(4 * ADDR_WORDS);

   wr_state_e               state, state_n;
   logic [AXI_IDS_BITS-1:0] id_q;
   logic [13:0]             addr_q;
   logic [AXI_LEN_BITS-1:0] len_q, cnt_q;
   logic                    incr_q, err_q;
   logic                    aw_hs, w_hs, last, in_range, bad_beat, aw_err;

   always_comb begin
      aw_hs    = awvalid_i & awready_o;
      w_hs     = wvalid_i & wready_o;
      in_range = 32'(addr_q) < WORDS;
      last     = wlast_i | (cnt_q == len_q);
      // a beat is bad on a WLAST/len disagreement, or if INCR walks off the end with beats left
      bad_beat = (wlast_i & (cnt_q < len_q)) | (~wlast_i & (cnt_q == len_q))
               | (incr_q & ~last & (32'(addr_q) + 32'd1 >= WORDS));
      aw_err   = (awsize_i != AXI_SIZE_WORD)
               | ~((awburst_i == AXI_BURST_FIXED) | (awburst_i == AXI_BURST_INCR))
               | (awaddr_i >= LIMIT);
      state_n  = state;
      state_n  = (state == IDLE && aw_hs) ? DATA :
                 (state == DATA && w_hs && last) ? RESP :
                 (state == RESP && bready_i) ? IDLE : state;
   end

   assign awready_o  = (state == IDLE) & rst;
   assign wready_o   = state == DATA;
   assign bvalid_o   = state == RESP;
   assign bid_o      = id_q;
   assign bresp_o    = (bvalid_o & err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   assign mem_cs_o   = w_hs & ~err_q & in_range;
   assign mem_we_o   = mem_cs_o ? wstrb_i : 4'd0;
   assign mem_addr_o = mem_cs_o ? addr_q : 14'd0;
   assign mem_di_o   = mem_cs_o ? wdata_i : 32'd0;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_n;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         id_q   <= '0;
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         incr_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (aw_hs) begin
         id_q   <= awid_i;
         addr_q <= awaddr_i[15:2];
         len_q  <= awlen_i;
         cnt_q  <= '0;
         incr_q <= awburst_i == AXI_BURST_INCR;
         err_q  <= aw_err;
      end else if (w_hs) begin
         cnt_q  <= cnt_q + 4'd1;
         err_q  <= err_q | bad_beat;
         if (incr_q) addr_q <= addr_q + 14'd1;
      end
endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// tb_axi_slave_wr_ctrl: directed vector table plus hand sequences for the write controller.
module tb_axi_slave_wr_ctrl;
   logic        clk = 0, rst = 0;
   logic [7:0]  awid = 0;
   logic [31:0] awaddr = 0;
   logic [3:0]  awlen = 0;
   logic [2:0]  awsize = 0;
   logic [1:0]  awburst = 0;
   logic        awvalid = 0, awready;
   logic [31:0] wdata = 0;
   logic [3:0]  wstrb = 0;
   logic        wlast = 0, wvalid = 0, wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready = 0;
   logic        mem_cs;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_di;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   axi_slave_wr_ctrl dut (
      .clk(clk), .rst(rst),
      .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
      .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
      .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
      .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_di_o(mem_di)
   );

   typedef struct {
      logic [7:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          nb;
      int          wlast_at;
      logic [3:0]  strb;
      int          writes;
      logic [13:0] first;
      bit          incr;
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input int k);
      logic [31:0] d;
      @(negedge clk);
      awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst; awvalid = 1;
      #1 chk($sformatf("v%0d awready", k), 32'(awready), 1);
      @(posedge clk);
      @(negedge clk);
      awvalid = 0;
      #1 chk($sformatf("v%0d wready_t+1", k), 32'(wready), 1);
      for (int b = 0; b < v.nb; b++) begin
         if (b > 0) @(negedge clk);
         d = 32'h1000 * 32'(k + 1) + 32'(b + 1);
         wvalid = 1; wdata = d; wstrb = v.strb; wlast = (b == v.wlast_at);
         #1;
         if (b < v.writes) begin
            chk($sformatf("v%0d b%0d cs", k, b), 32'(mem_cs), 1);
            chk($sformatf("v%0d b%0d we", k, b), 32'(mem_we), 32'(v.strb));
            chk($sformatf("v%0d b%0d addr", k, b), 32'(mem_addr), 32'(v.first + (v.incr ? 14'(b) : 14'd0)));
            chk($sformatf("v%0d b%0d di", k, b), mem_di, d);
         end else begin
            chk($sformatf("v%0d b%0d cs_drop", k, b), 32'(mem_cs), 0);
            chk($sformatf("v%0d b%0d we_drop", k, b), 32'(mem_we), 0);
         end
         @(posedge clk);
      end
      @(negedge clk);
      wvalid = 0; wlast = 0;
      #1;
      chk($sformatf("v%0d bvalid", k), 32'(bvalid), 1);
      chk($sformatf("v%0d bid", k), 32'(bid), 32'(v.id));
      chk($sformatf("v%0d bresp", k), 32'(bresp), 32'(v.resp));
      chk($sformatf("v%0d awready_resp", k), 32'(awready), 0);
      bready = 1;
      @(posedge clk);
      @(negedge clk);
      bready = 0;
      #1;
      chk($sformatf("v%0d awready_after_b", k), 32'(awready), 1);
      chk($sformatf("v%0d bvalid_after_b", k), 32'(bvalid), 0);
   endtask

   initial begin
      vecs[0] = '{8'h12, 32'h100,   4'd3,  3'b010, 2'b01, 4,  3,  4'hF, 4,  14'h40,   1, 2'b00};
      vecs[1] = '{8'h34, 32'h20,    4'd1,  3'b010, 2'b00, 2,  1,  4'h3, 2,  14'h8,    0, 2'b00};
      vecs[2] = '{8'h56, 32'h200,   4'd3,  3'b010, 2'b01, 2,  1,  4'hF, 2,  14'h80,   1, 2'b10};
      vecs[3] = '{8'h78, 32'hFFFC,  4'd1,  3'b010, 2'b01, 2,  1,  4'hF, 1,  14'h3FFF, 1, 2'b10};
      vecs[4] = '{8'h9A, 32'h40,    4'd1,  3'b010, 2'b10, 2,  1,  4'hF, 0,  14'h10,   1, 2'b10};
      vecs[5] = '{8'hBC, 32'h40,    4'd0,  3'b001, 2'b01, 1,  0,  4'hF, 0,  14'h10,   1, 2'b10};
      vecs[6] = '{8'hDE, 32'h0,     4'd15, 3'b010, 2'b01, 16, 15, 4'hC, 16, 14'h0,    1, 2'b00};
      vecs[7] = '{8'hF0, 32'h300,   4'd1,  3'b010, 2'b01, 2,  15, 4'h5, 2,  14'hC0,   1, 2'b10};
      vecs[8] = '{8'h11, 32'h10000, 4'd0,  3'b010, 2'b01, 1,  0,  4'hF, 0,  14'h0,    1, 2'b10};

      #12;
      chk("rst awready", 32'(awready), 0);
      chk("rst wready", 32'(wready), 0);
      chk("rst bvalid", 32'(bvalid), 0);
      chk("rst mem_cs", 32'(mem_cs), 0);
      chk("rst mem_we", 32'(mem_we), 0);
      chk("rst mem_addr", 32'(mem_addr), 0);
      chk("rst mem_di", mem_di, 0);
      chk("rst bid", 32'(bid), 0);
      chk("rst bresp", 32'(bresp), 0);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      #1 chk("awready after release", 32'(awready), 1);

      wvalid = 1; wlast = 1; wdata = 32'hDEAD; wstrb = 4'hF;
      #1;
      chk("early w wready", 32'(wready), 0);
      chk("early w mem_cs", 32'(mem_cs), 0);
      @(posedge clk);
      @(negedge clk);
      wvalid = 0; wlast = 0;
      #1 chk("early w still idle", 32'(awready), 1);

      for (int k = 0; k < 9; k++) run(vecs[k], k);

      @(negedge clk);
      awid = 8'h5A; awaddr = 32'h40; awlen = 0; awsize = 3'b010; awburst = 2'b01; awvalid = 1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 0; wvalid = 1; wlast = 1; wdata = 32'h55; wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      wvalid = 0; wlast = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("hold%0d bvalid", i), 32'(bvalid), 1);
         chk($sformatf("hold%0d bid", i), 32'(bid), 32'h5A);
         chk($sformatf("hold%0d bresp", i), 32'(bresp), 0);
         chk($sformatf("hold%0d awready", i), 32'(awready), 0);
         @(negedge clk);
      end
      bready = 1;
      @(posedge clk);
      @(negedge clk);
      bready = 0;
      #1 chk("hold awready after b", 32'(awready), 1);

      @(negedge clk);
      awid = 8'h77; awaddr = 32'h400; awlen = 3; awsize = 3'b010; awburst = 2'b01; awvalid = 1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 0; wvalid = 1; wlast = 0; wdata = 32'h1; wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      wdata = 32'h2;
      #2 rst = 0;
      #1;
      chk("midrst wready", 32'(wready), 0);
      chk("midrst mem_cs", 32'(mem_cs), 0);
      chk("midrst bvalid", 32'(bvalid), 0);
      chk("midrst awready", 32'(awready), 0);
      chk("midrst bid", 32'(bid), 0);
      wvalid = 0;
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst awready after release", 32'(awready), 1);
      chk("midrst no b", 32'(bvalid), 0);
      run(vecs[1], 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
